traffic_lights_cmd_parser: RTL and testbench

- Upstream stage of traffic_lights_top. Assembles a byte stream from the host serial receiver into framed commands.
- Drives cmd_type/cmd_valid/cmd_data with a single-cycle valid pulse.
- Checks frames for opcode validity, checksum and inter-byte timeout, and reports errors and counts.

---
 rtl/definitions_pkg.sv | 14 +
 rtl/traffic_lights_cmd_parser.sv | 166 ++++++++++++++++
 tb/tb_traffic_lights_cmd_parser.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/definitions_pkg.sv
// Shared types for the traffic lights subsystem.
//   command_e : host command decoded from a frame opcode (value equals opcode).
package definitions_pkg;

    typedef enum logic [2:0] {
        CMD_ON          = 3'd0,
        CMD_OFF         = 3'd1,
        CMD_UNREGULATED = 3'd2,
        CMD_GREEN_TIME  = 3'd3,
        CMD_RED_TIME    = 3'd4,
        CMD_YELLOW_TIME = 3'd5
    } command_e;

endpackage

// File: rtl/traffic_lights_cmd_parser.sv
// Assembles 4-byte host frames (OPC, DHI, DLO, CHK) into commands.
// Ports:
//   clk_2k_i      : system clock (2 kHz)
//   arst_n_i      : asynchronous active-low reset
//   byte_i        : received byte, transferred when byte_valid_i && byte_ready_o
//   byte_valid_i  : byte_i valid
//   byte_ready_o  : parser can accept a byte (low only in the emit cycle)
//   cmd_type_o    : decoded command, held until the next good frame
//   cmd_valid_o   : one-cycle command strobe
//   cmd_data_o    : command payload {DHI, DLO}, held until the next good frame
//   err_o         : one-cycle error strobe
//   err_code_o    : 1 = bad opcode, 2 = bad checksum, 3 = inter-byte timeout
//   frame_cnt_o   : saturating count of good frames
//   err_cnt_o     : saturating count of errors
module traffic_lights_cmd_parser
    import definitions_pkg::*;
#(
    parameter int unsigned TIMEOUT_TICKS = 2000,
    parameter int unsigned CNT_W         = 16
) (
    input  logic             clk_2k_i,
    input  logic             arst_n_i,
    input  logic [7:0]       byte_i,
    input  logic             byte_valid_i,
    output logic             byte_ready_o,
    output command_e         cmd_type_o,
    output logic             cmd_valid_o,
    output logic [15:0]      cmd_data_o,
    output logic             err_o,
    output logic [1:0]       err_code_o,
    output logic [CNT_W-1:0] frame_cnt_o,
    output logic [CNT_W-1:0] err_cnt_o
);

    localparam int unsigned    TMO_W    = 16;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_TICKS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    localparam logic [1:0] ERR_OPC = 2'd1;
    localparam logic [1:0] ERR_CHK = 2'd2;
    localparam logic [1:0] ERR_TMO = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GOT_OPC,
        S_GOT_DHI,
        S_GOT_DLO,
        S_EMIT
    } state_e;

    state_e           state_q, state_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [7:0]       opc_q, dhi_q, dlo_q, chk_q;
    logic             accept_c;
    logic             cmd_fire_c, err_fire_c;
    logic [1:0]       err_code_c;
    logic             opc_ok_c, chk_ok_c;

    assign accept_c = byte_valid_i && byte_ready_o;
    assign opc_ok_c = (opc_q <= 8'h05);
    assign chk_ok_c = (chk_q == (opc_q ^ dhi_q ^ dlo_q));

    // State and inter-byte timeout counter
    always_ff @(posedge clk_2k_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q <= S_IDLE;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
        end
    end

    // Next state, timeout and frame checks; an accepted byte beats a timeout
    always_comb begin
        state_d    = state_q;
        tmo_d      = tmo_q;
        cmd_fire_c = 1'b0;
        err_fire_c = 1'b0;
        err_code_c = 2'd0;
        case (state_q)
            S_IDLE: begin
                tmo_d = '0;
                if (accept_c) state_d = S_GOT_OPC;
            end
            S_GOT_OPC, S_GOT_DHI, S_GOT_DLO: begin
                if (accept_c) begin
                    tmo_d = '0;
                    case (state_q)
                        S_GOT_OPC: state_d = S_GOT_DHI;
                        S_GOT_DHI: state_d = S_GOT_DLO;
                        default:   state_d = S_EMIT;
                    endcase
                end else if (tmo_q == TMO_LAST) begin
                    tmo_d      = '0;
                    state_d    = S_IDLE;
                    err_fire_c = 1'b1;
                    err_code_c = ERR_TMO;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_EMIT: begin
                state_d = S_IDLE;
                tmo_d   = '0;
                if (!opc_ok_c) begin
                    err_fire_c = 1'b1;
                    err_code_c = ERR_OPC;
                end else if (!chk_ok_c) begin
                    err_fire_c = 1'b1;
                    err_code_c = ERR_CHK;
                end else begin
                    cmd_fire_c = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                tmo_d   = '0;
            end
        endcase
    end

    // Frame byte capture
    always_ff @(posedge clk_2k_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            opc_q <= '0;
            dhi_q <= '0;
            dlo_q <= '0;
            chk_q <= '0;
        end else if (accept_c) begin
            case (state_q)
                S_IDLE:    opc_q <= byte_i;
                S_GOT_OPC: dhi_q <= byte_i;
                S_GOT_DHI: dlo_q <= byte_i;
                S_GOT_DLO: chk_q <= byte_i;
                default:   ;
            endcase
        end
    end

    // Registered outputs and saturating counters
    always_ff @(posedge clk_2k_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            byte_ready_o <= 1'b1;
            cmd_valid_o  <= 1'b0;
            cmd_type_o   <= CMD_ON;
            cmd_data_o   <= '0;
            err_o        <= 1'b0;
            err_code_o   <= '0;
            frame_cnt_o  <= '0;
            err_cnt_o    <= '0;
        end else begin
            byte_ready_o <= (state_d != S_EMIT);
            cmd_valid_o  <= cmd_fire_c;
            err_o        <= err_fire_c;
            err_code_o   <= err_code_c;
            if (cmd_fire_c) begin
                cmd_type_o <= command_e'(opc_q[2:0]);
                cmd_data_o <= {dhi_q, dlo_q};
                if (frame_cnt_o != CNT_MAX) frame_cnt_o <= frame_cnt_o + CNT_W'(1);
            end
            if (err_fire_c && (err_cnt_o != CNT_MAX)) err_cnt_o <= err_cnt_o + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_traffic_lights_cmd_parser.sv
// Self-checking bench for traffic_lights_cmd_parser (TIMEOUT_TICKS=8, CNT_W=2).
module tb_traffic_lights_cmd_parser;
    import definitions_pkg::*;

    localparam int unsigned TMO = 8;
    localparam int unsigned CW  = 2;

    logic          clk_2k_i     = 1'b0;
    logic          arst_n_i     = 1'b0;
    logic [7:0]    byte_i       = 8'h00;
    logic          byte_valid_i = 1'b0;
    logic          byte_ready_o;
    command_e      cmd_type_o;
    logic          cmd_valid_o;
    logic [15:0]   cmd_data_o;
    logic          err_o;
    logic [1:0]    err_code_o;
    logic [CW-1:0] frame_cnt_o;
    logic [CW-1:0] err_cnt_o;

    int total = 0;
    int bad   = 0;
    int n_good = 0;
    int n_err  = 0;
    logic [23:0] obs_q[$];

    traffic_lights_cmd_parser #(.TIMEOUT_TICKS(TMO), .CNT_W(CW)) dut (
        .clk_2k_i    (clk_2k_i),
        .arst_n_i    (arst_n_i),
        .byte_i      (byte_i),
        .byte_valid_i(byte_valid_i),
        .byte_ready_o(byte_ready_o),
        .cmd_type_o  (cmd_type_o),
        .cmd_valid_o (cmd_valid_o),
        .cmd_data_o  (cmd_data_o),
        .err_o       (err_o),
        .err_code_o  (err_code_o),
        .frame_cnt_o (frame_cnt_o),
        .err_cnt_o   (err_cnt_o)
    );

    always #5 clk_2k_i = ~clk_2k_i;

    // Saturating reference count
    function automatic logic [CW-1:0] sat(input int n);
        int mx;
        mx = (1 << CW) - 1;
        return (n > mx) ? CW'(mx) : CW'(n);
    endfunction

    // Reference outcome of one frame: {is_err, code, 2'b0, type, data}
    function automatic logic [23:0] model(input logic [7:0] o, input logic [7:0] h,
                                          input logic [7:0] l, input logic [7:0] c);
        if (o > 8'd5) return {1'b1, 2'd1, 21'd0};
        if (c != (o ^ h ^ l)) return {1'b1, 2'd2, 21'd0};
        return {1'b0, 2'd0, 2'd0, o[2:0], h, l};
    endfunction

    // Strobe monitor: records every strobe and checks they never coincide
    always @(negedge clk_2k_i) begin
        if (arst_n_i && (cmd_valid_o || err_o)) begin
            total++;
            if (cmd_valid_o && err_o) begin
                bad++;
                $display("FAIL strobe_excl: cmd_valid_o=%b err_o=%b, required not both", cmd_valid_o, err_o);
            end
            if (cmd_valid_o) obs_q.push_back({1'b0, 2'd0, 2'd0, 3'(cmd_type_o), cmd_data_o});
            if (err_o)       obs_q.push_back({1'b1, err_code_o, 21'd0});
        end
    end

    // Offer one byte after 'gap' idle cycles; returns at the negedge after the transfer
    task automatic send_byte(input logic [7:0] b, input int gap);
        int w;
        repeat (gap) begin
            byte_valid_i = 1'b0;
            @(negedge clk_2k_i);
        end
        byte_i       = b;
        byte_valid_i = 1'b1;
        w = 0;
        while (!byte_ready_o && w < 20) begin
            @(negedge clk_2k_i);
            w++;
        end
        if (w >= 20) begin
            total++;
            bad++;
            $display("FAIL ready_wait: byte_ready_o stuck at %b, required 1", byte_ready_o);
        end
        @(negedge clk_2k_i);
    endtask

    task automatic send_frame(input logic [7:0] o, input logic [7:0] h,
                              input logic [7:0] l, input logic [7:0] c, input int maxgap);
        send_byte(o, $urandom_range(0, maxgap));
        send_byte(h, $urandom_range(0, maxgap));
        send_byte(l, $urandom_range(0, maxgap));
        send_byte(c, $urandom_range(0, maxgap));
        byte_valid_i = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk_2k_i);
        total++; if (byte_ready_o !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", byte_ready_o); end
        total++; if (cmd_valid_o !== 1'b0) begin bad++; $display("FAIL rst_cmd_valid: got %b want 0", cmd_valid_o); end
        total++; if (err_o !== 1'b0 || err_code_o !== 2'd0) begin bad++; $display("FAIL rst_err: got %b/%0d want 0/0", err_o, err_code_o); end
        total++; if (3'(cmd_type_o) !== 3'd0 || cmd_data_o !== 16'h0) begin bad++; $display("FAIL rst_cmd: got %0d/%h want 0/0000", cmd_type_o, cmd_data_o); end
        total++; if (frame_cnt_o !== '0 || err_cnt_o !== '0) begin bad++; $display("FAIL rst_cnt: got %0d/%0d want 0/0", frame_cnt_o, err_cnt_o); end
        arst_n_i = 1'b1;
        @(negedge clk_2k_i);
    endtask

    task automatic test_good_frame;
        send_byte(8'h03, 0);
        send_byte(8'h00, 0);
        send_byte(8'h14, 0);
        send_byte(8'h17, 0);
        // valid still high here: the source holds the next offer while ready is low
        total++; if (byte_ready_o !== 1'b0) begin bad++; $display("FAIL emit_ready: got %b want 0", byte_ready_o); end
        total++; if (cmd_valid_o !== 1'b0) begin bad++; $display("FAIL early_strobe: got %b want 0", cmd_valid_o); end
        byte_valid_i = 1'b0;
        @(negedge clk_2k_i);
        n_good++;
        total++; if (byte_ready_o !== 1'b1) begin bad++; $display("FAIL post_emit_ready: got %b want 1", byte_ready_o); end
        total++; if (cmd_valid_o !== 1'b1) begin bad++; $display("FAIL good_valid: got %b want 1", cmd_valid_o); end
        total++; if (cmd_type_o !== CMD_GREEN_TIME || cmd_data_o !== 16'h0014) begin bad++; $display("FAIL good_cmd: got %0d/%h want 3/0014", cmd_type_o, cmd_data_o); end
        total++; if (frame_cnt_o !== sat(n_good)) begin bad++; $display("FAIL good_cnt: got %0d want %0d", frame_cnt_o, sat(n_good)); end
        @(negedge clk_2k_i);
        total++; if (cmd_valid_o !== 1'b0) begin bad++; $display("FAIL pulse_width: got %b want 0", cmd_valid_o); end
    endtask

    task automatic test_bad_frames;
        send_frame(8'h04, 8'h12, 8'h34, 8'h00, 0);
        @(negedge clk_2k_i);
        n_err++;
        total++; if (err_o !== 1'b1 || err_code_o !== 2'd2) begin bad++; $display("FAIL bad_chk: got %b/%0d want 1/2", err_o, err_code_o); end
        total++; if (cmd_valid_o !== 1'b0) begin bad++; $display("FAIL bad_chk_valid: got %b want 0", cmd_valid_o); end
        total++; if (err_cnt_o !== sat(n_err)) begin bad++; $display("FAIL bad_chk_cnt: got %0d want %0d", err_cnt_o, sat(n_err)); end
        total++; if (cmd_data_o !== 16'h0014) begin bad++; $display("FAIL data_hold: got %h want 0014", cmd_data_o); end
        send_frame(8'h09, 8'h00, 8'h00, 8'h00, 3);
        @(negedge clk_2k_i);
        n_err++;
        total++; if (err_o !== 1'b1 || err_code_o !== 2'd1) begin bad++; $display("FAIL bad_opc: got %b/%0d want 1/1", err_o, err_code_o); end
        total++; if (err_cnt_o !== sat(n_err)) begin bad++; $display("FAIL bad_opc_cnt: got %0d want %0d", err_cnt_o, sat(n_err)); end
    endtask

    task automatic test_timeout;
        send_byte(8'h00, 0);
        byte_valid_i = 1'b0;
        repeat (TMO - 1) @(negedge clk_2k_i);
        total++; if (err_o !== 1'b0) begin bad++; $display("FAIL tmo_early: got %b want 0", err_o); end
        @(negedge clk_2k_i);
        n_err++;
        total++; if (err_o !== 1'b1 || err_code_o !== 2'd3) begin bad++; $display("FAIL tmo: got %b/%0d want 1/3", err_o, err_code_o); end
        total++; if (err_cnt_o !== sat(n_err)) begin bad++; $display("FAIL tmo_cnt: got %0d want %0d", err_cnt_o, sat(n_err)); end
        @(negedge clk_2k_i);
        send_frame(8'h00, 8'h00, 8'h00, 8'h00, 0);
        @(negedge clk_2k_i);
        n_good++;
        total++; if (cmd_valid_o !== 1'b1 || cmd_type_o !== CMD_ON || cmd_data_o !== 16'h0000) begin bad++; $display("FAIL post_tmo: got %b/%0d/%h want 1/0/0000", cmd_valid_o, cmd_type_o, cmd_data_o); end
        // Gaps one cycle short of the limit must keep the frame alive
        send_byte(8'h01, 0);
        send_byte(8'hAB, TMO - 1);
        send_byte(8'hCD, TMO - 1);
        send_byte(8'h01 ^ 8'hAB ^ 8'hCD, TMO - 1);
        byte_valid_i = 1'b0;
        @(negedge clk_2k_i);
        n_good++;
        total++; if (cmd_valid_o !== 1'b1 || cmd_type_o !== CMD_OFF || cmd_data_o !== 16'hABCD) begin bad++; $display("FAIL gap_edge: got %b/%0d/%h want 1/1/abcd", cmd_valid_o, cmd_type_o, cmd_data_o); end
        total++; if (err_o !== 1'b0) begin bad++; $display("FAIL gap_edge_err: got %b want 0", err_o); end
    endtask

    task automatic test_saturation;
        logic [7:0] o, h, l;
        for (int i = 0; i < 5; i++) begin
            o = 8'($urandom_range(0, 5));
            h = 8'($urandom);
            l = 8'($urandom);
            send_frame(o, h, l, o ^ h ^ l, 2);
            @(negedge clk_2k_i);
            n_good++;
            total++; if (cmd_valid_o !== 1'b1 || cmd_data_o !== {h, l}) begin bad++; $display("FAIL sat_frame%0d: got %b/%h want 1/%h", i, cmd_valid_o, cmd_data_o, {h, l}); end
        end
        total++; if (frame_cnt_o !== 2'd3 || frame_cnt_o !== sat(n_good)) begin bad++; $display("FAIL frame_sat: got %0d want 3", frame_cnt_o); end
        total++; if (err_cnt_o !== sat(n_err)) begin bad++; $display("FAIL err_sat: got %0d want %0d", err_cnt_o, sat(n_err)); end
    endtask

    task automatic test_reset_mid_frame;
        logic [7:0] c;
        send_byte(8'h05, 0);
        send_byte(8'h12, 0);
        byte_valid_i = 1'b0;
        #2 arst_n_i = 1'b0;
        #1;
        n_good = 0;
        n_err  = 0;
        total++; if (frame_cnt_o !== '0 || err_cnt_o !== '0) begin bad++; $display("FAIL mid_rst_cnt: got %0d/%0d want 0/0", frame_cnt_o, err_cnt_o); end
        total++; if (3'(cmd_type_o) !== 3'd0 || cmd_data_o !== 16'h0 || cmd_valid_o !== 1'b0 || err_o !== 1'b0) begin bad++; $display("FAIL mid_rst_out: got %0d/%h/%b/%b want 0/0000/0/0", cmd_type_o, cmd_data_o, cmd_valid_o, err_o); end
        total++; if (byte_ready_o !== 1'b1) begin bad++; $display("FAIL mid_rst_ready: got %b want 1", byte_ready_o); end
        @(negedge clk_2k_i);
        arst_n_i = 1'b1;
        @(negedge clk_2k_i);
        c = 8'h05 ^ 8'h12 ^ 8'h34;
        send_frame(8'h05, 8'h12, 8'h34, c, 0);
        @(negedge clk_2k_i);
        n_good++;
        total++; if (cmd_valid_o !== 1'b1 || cmd_type_o !== CMD_YELLOW_TIME || cmd_data_o !== 16'h1234) begin bad++; $display("FAIL post_rst: got %b/%0d/%h want 1/5/1234", cmd_valid_o, cmd_type_o, cmd_data_o); end
        total++; if (frame_cnt_o !== sat(n_good)) begin bad++; $display("FAIL post_rst_cnt: got %0d want %0d", frame_cnt_o, sat(n_good)); end
    endtask

    task automatic test_back_to_back;
        logic [23:0] exp_q[$];
        logic [23:0] e, g;
        logic [7:0]  o, h, l, c;
        int          n;
        repeat (3) @(negedge clk_2k_i);
        obs_q.delete();
        for (int i = 0; i < 40; i++) begin
            o = 8'($urandom_range(0, 7));
            h = 8'($urandom);
            l = 8'($urandom);
            c = o ^ h ^ l;
            if ($urandom_range(0, 3) == 0) c = c ^ 8'($urandom_range(1, 255));
            e = model(o, h, l, c);
            exp_q.push_back(e);
            if (e[23]) n_err++; else n_good++;
            send_frame(o, h, l, c, TMO - 1);
        end
        repeat (4) @(negedge clk_2k_i);
        total++; if (obs_q.size() !== exp_q.size()) begin bad++; $display("FAIL b2b_count: got %0d events want %0d", obs_q.size(), exp_q.size()); end
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            g = obs_q[i];
            e = exp_q[i];
            total++; if (g !== e) begin bad++; $display("FAIL b2b_event%0d: got %h want %h", i, g, e); end
        end
        total++; if (frame_cnt_o !== sat(n_good) || err_cnt_o !== sat(n_err)) begin bad++; $display("FAIL b2b_cnt: got %0d/%0d want %0d/%0d", frame_cnt_o, err_cnt_o, sat(n_good), sat(n_err)); end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_frames();
        test_timeout();
        test_saturation();
        test_reset_mid_frame();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
